// File: rtl/pc_gen_if.sv
// Fetch-side handshake between the PC generator and the fetch stage.
// master drives pc/pc_valid and samples pc_ready; slave is the fetch side.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            pc_ready;

    modport master (
        output pc,
        output pc_valid,
        input  pc_ready
    );

    modport slave (
        input  pc,
        input  pc_valid,
        output pc_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with prioritised redirects and a return-address stack.
// Ports: clk, rst_n (async, active-low); trap_valid/trap_pc, flush_pc/new_pc,
//   br_valid/br_taken/jal_valid/ex_pc/ex_offset (EX redirects);
//   id_call/id_ret/id_pc (RAS control); fetch (pc/pc_valid/pc_ready);
//   ras_count (valid RAS entries).
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              INST_BYTES = 4,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         trap_valid,
    input  logic [XLEN-1:0]              trap_pc,
    input  logic                         flush_pc,
    input  logic [XLEN-1:0]              new_pc,
    input  logic                         br_valid,
    input  logic                         br_taken,
    input  logic                         jal_valid,
    input  logic [XLEN-1:0]              ex_pc,
    input  logic [XLEN-1:0]              ex_offset,
    input  logic                         id_call,
    input  logic                         id_ret,
    input  logic [XLEN-1:0]              id_pc,
    pc_gen_if.master                     fetch,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [XLEN-1:0] INC  = XLEN'(INST_BYTES);
    localparam logic [CW-1:0]   FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            valid_q;
    logic [PW-1:0]   tp_q;
    logic [PW-1:0]   tp_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic [XLEN-1:0] ras [RAS_DEPTH];

    logic            ex_redir;
    logic            wrong_path;
    logic            call_ok;
    logic            ret_ok;
    logic            ras_empty;
    logic            ret_redir;
    logic            fire;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] ret_addr;
    logic            ras_we;
    logic [PW-1:0]   ras_waddr;

    assign fetch.pc       = pc_q;
    assign fetch.pc_valid = valid_q;
    assign ras_count      = cnt_q;

    always_comb begin
        ex_redir   = (br_valid & br_taken) | jal_valid;
        wrong_path = trap_valid | flush_pc | ex_redir;
        // Calls/returns decoded on a path about to be squashed must not
        // disturb the stack.
        call_ok    = id_call & ~wrong_path;
        ret_ok     = id_ret & ~wrong_path;
        ras_empty  = (cnt_q == '0);
        ret_redir  = ret_ok & ~ras_empty;
        fire       = valid_q & fetch.pc_ready;
        ras_top    = ras[tp_q];
        ret_addr   = id_pc + INC;
    end

    // Next-PC selection, first match wins.
    always_comb begin
        pc_d = pc_q;
        priority case (1'b1)
            trap_valid: pc_d = trap_pc;
            flush_pc:   pc_d = new_pc;
            ex_redir:   pc_d = ex_pc + ex_offset;
            ret_redir:  pc_d = ras_top;
            fire:       pc_d = pc_q + INC;
            default:    pc_d = pc_q;
        endcase
    end

    // RAS pointer/count update. A simultaneous call+return replaces the
    // top entry in place: the pop and push cancel out on tp and count.
    always_comb begin
        tp_d      = tp_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = tp_q;
        if (call_ok && ret_ok) begin
            ras_we    = 1'b1;
            ras_waddr = tp_q;
            if (ras_empty) begin
                cnt_d = CW'(1);
            end
        end else if (call_ok) begin
            ras_we    = 1'b1;
            ras_waddr = tp_q + PW'(1);
            tp_d      = tp_q + PW'(1);
            // Overflow wraps onto the oldest entry; count saturates.
            if (cnt_q != FULL) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (ret_ok && !ras_empty) begin
            tp_d  = tp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            tp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            tp_q    <= tp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stack contents need no reset; entries are only read when counted.
    always_ff @(posedge clk) begin
        if (rst_n && ras_we) begin
            ras[ras_waddr] <= ret_addr;
        end
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the aurora CPU front end, and the next-generation replacement for the single-offset PC register. It supplies the fetch stage with a PC over a valid/ready handshake and holds the PC while fetch stalls. It arbitrates four redirect sources: trap, jalr flush, branch/jal resolution in EX, and return prediction in ID. A parametrised return-address stack (RAS) predicts function returns.

## Interface
Parameters:
- XLEN, 32, PC and offset width
- RESET_PC, 32'h0000_0000, PC value loaded at reset (XLEN bits)
- INST_BYTES, 4, sequential increment
- RAS_DEPTH, 4, RAS entries; power of two, ≥2

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- trap_valid  in  1  trap/exception redirect
- trap_pc  in  XLEN  trap vector
- flush_pc  in  1  jalr redirect from EX
- new_pc  in  XLEN  jalr target
- br_valid  in  1  conditional branch resolved in EX
- br_taken  in  1  branch condition true; qualified by br_valid
- jal_valid  in  1  jal resolved in EX
- ex_pc  in  XLEN  PC of the EX instruction
- ex_offset  in  XLEN  sign-extended branch/jal offset
- id_call  in  1  decoded call (jal/jalr with rd=x1/x5)
- id_ret  in  1  decoded return (jalr x0, x1/x5, 0)
- id_pc  in  XLEN  PC of the ID instruction
- pc  out  XLEN  current fetch PC (register)
- pc_valid  out  1  pc offered to fetch
- pc_ready  in  1  fetch accepts pc
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries

## Operation
- The next PC is selected by a fixed priority, first match wins:
  1. trap_valid: next PC = trap_pc.
  2. flush_pc: next PC = new_pc.
  3. ex_redir = (br_valid & br_taken) | jal_valid: next PC = ex_pc + ex_offset.
  4. id_ret & (ras_count != 0): next PC = RAS top (pop).
  5. pc_valid & pc_ready: next PC = pc + INST_BYTES.
  6. Otherwise: hold pc.
- Redirects 1–4 load pc whether or not pc_ready is high; a stalled PC is replaced, not queued.
- All additions are modulo 2^XLEN (wrap, no carry-out). ex_offset is XLEN-bit two's complement.
- RAS is a circular buffer with top pointer `tp` and saturating ras_count.
  - Push on id_call: write id_pc + INST_BYTES at tp+1; tp increments; count saturates at RAS_DEPTH.
  - Overflow overwrites the oldest entry silently.
  - Pop on id_ret with count > 0: read top; tp decrements; count decrements.
  - Pop when empty: no redirect, no pointer change, count stays 0.
  - id_call & id_ret in the same cycle: the return target is the old top, then top is overwritten with id_pc + INST_BYTES. tp and count are unchanged, except that count 0 becomes 1 and there is no redirect.
- When trap_valid, flush_pc or ex_redir is set, id_call and id_ret are ignored (wrong path). The RAS is untouched.
- Trap and flush do not clear the RAS.

## Timing
- Reset: pc = RESET_PC, pc_valid = 0, ras_count = 0, tp = 0; RAS contents are don't-care.
- pc_valid rises on the first rising edge after rst_n deasserts and then stays 1 (held low only by reset).
- Redirect latency is 1 cycle: a redirect sampled at edge N gives pc = target after edge N.
- Handshake: a transfer occurs when pc_valid & pc_ready at a rising edge. pc is stable while pc_valid & !pc_ready, unless a redirect is applied.
- RAS push and pop take effect at the same edge as the pc update. ras_count is registered.
- Reset asserted mid-operation forces the reset values immediately (asynchronous), including any in-flight redirect.

## Test plan
- Reset/sequential: release reset, hold pc_ready=1 → pc = RESET_PC, then RESET_PC+4, +8; pc_valid 0 in the reset cycle and 1 afterwards.
- Stall + redirect: pc_ready=0 at pc=0x100 for 3 cycles → pc holds 0x100. Then assert flush_pc with new_pc=0x2000 while pc_ready=0 → pc = 0x2000 next cycle.
- Priority: assert trap_valid (0x80), flush_pc (0x400) and jal_valid (ex_pc 0x10, offset -8) together → pc = 0x80. With flush_pc and jal_valid only → 0x400. With jal_valid only → 0x08.
- Wrap: ex_pc = 0xFFFF_FFFC, ex_offset = 8, br_valid = br_taken = 1 → pc = 0x0000_0004. With br_taken = 0 → sequential advance.
- RAS: 5 calls at id_pc 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) → ras_count = 4. Then 5 returns → pc = 0x54, 0x44, 0x34, 0x24. The fifth return is sequential with count 0.
- Simultaneous: top = 0x44 and id_call & id_ret at id_pc 0x60 → pc = 0x44, top becomes 0x64, count unchanged. id_ret with ex_redir in the same cycle → EX target taken, RAS unchanged.
